fft_mc_dma: RTL and testbench

- Memory-controller-side DMA agent for the FFT accelerator; drives the other end of its 512-bit block interface.
- Per signal: reads 128 blocks of 512 bits (1024 complex 64-bit samples) from host memory and pushes them into the accelerator in-FIFO.
- Then drains 128 result blocks from the out-FIFO back to host memory, acknowledging each block.

---
 rtl/fft_mc_dma.sv | 203 ++++++++++++++++++++
 tb/tb_fft_mc_dma.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mc_dma.sv
// fft_mc_dma: host-memory DMA agent that feeds and drains the FFT accelerator.
// Define FFT_DMA_TIMEOUT_EN to add a watchdog that aborts stalled transfers.
module fft_mc_dma #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [ADDR_W-1:0] IN_BASE = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(32'h1000_0000),
    parameter int unsigned BLKS = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [17:0]       sigNum,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              memRdReq,
    output logic [ADDR_W-1:0] memRdAddr,
    input  logic              memRdGnt,
    input  logic              memRdValid,
    input  logic [511:0]      memRdData,
    output logic              memWrReq,
    output logic [ADDR_W-1:0] memWrAddr,
    output logic [511:0]      memWrData,
    input  logic              memWrGnt,
    output logic              loadInFifo,
    output logic [511:0]      mcDataIn,
    input  logic              inFifoEmpty,
    input  logic              outFifoReady,
    input  logic [511:0]      mcDataOut,
    input  logic              mcDataOutValid,
    output logic              accelWrBlkDone
);

    localparam int unsigned BW = (BLKS > 1) ? $clog2(BLKS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BLKS - 1);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_EMPTY,
        RD_REQ,
        RD_DATA,
        PUSH,
        WAIT_OUT,
        WR_CAP,
        WR_REQ,
        ACK,
        FINISH
    } state_t;

    state_t        state;
    logic [17:0]   sig;
    logic [BW-1:0] blk;
    logic [511:0]  data;

    // Read and write phases never overlap, so one block register serves both.
    assign mcDataIn  = data;
    assign memWrData = data;

    function automatic logic [ADDR_W-1:0] blk_addr(
        input logic [ADDR_W-1:0] base,
        input logic [17:0]       s,
        input logic [BW-1:0]     b
    );
        return base + ADDR_W'({s, 13'b0}) + ADDR_W'({b, 6'b0});
    endfunction

`ifdef FFT_DMA_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo;
    logic          stall;
    logic          tmo_hit;

    // In the counted states, any cycle that makes progress also changes state.
    assign stall = (state == RD_REQ  && !memRdGnt)
                || (state == RD_DATA && !memRdValid)
                || (state == WR_CAP  && !mcDataOutValid)
                || (state == WR_REQ  && !memWrGnt);
    assign tmo_hit = stall && (tmo == TW'(TIMEOUT_CYCLES - 1));
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            sig            <= '0;
            blk            <= '0;
            data           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            memRdReq       <= 1'b0;
            memRdAddr      <= '0;
            memWrReq       <= 1'b0;
            memWrAddr      <= '0;
            loadInFifo     <= 1'b0;
            accelWrBlkDone <= 1'b0;
`ifdef FFT_DMA_TIMEOUT_EN
            tmo            <= '0;
            err            <= 1'b0;
`endif
        end else begin
            done           <= 1'b0;
            loadInFifo     <= 1'b0;
            accelWrBlkDone <= 1'b0;
`ifdef FFT_DMA_TIMEOUT_EN
            err            <= 1'b0;
            tmo            <= stall ? tmo + 1'b1 : '0;
            if (tmo_hit) begin
                state    <= IDLE;
                busy     <= 1'b0;
                memRdReq <= 1'b0;
                memWrReq <= 1'b0;
                blk      <= '0;
                tmo      <= '0;
                err      <= 1'b1;
            end else begin
`else
            begin
`endif
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            sig   <= sigNum;
                            blk   <= '0;
                            busy  <= 1'b1;
                            state <= WAIT_EMPTY;
                        end
                    end
                    WAIT_EMPTY: begin
                        if (inFifoEmpty) begin
                            memRdReq  <= 1'b1;
                            memRdAddr <= blk_addr(IN_BASE, sig, blk);
                            state     <= RD_REQ;
                        end
                    end
                    RD_REQ: begin
                        if (memRdGnt) begin
                            memRdReq <= 1'b0;
                            state    <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (memRdValid) begin
                            data       <= memRdData;
                            loadInFifo <= 1'b1;
                            state      <= PUSH;
                        end
                    end
                    PUSH: begin
                        if (blk == LAST) begin
                            blk   <= '0;
                            state <= WAIT_OUT;
                        end else begin
                            blk       <= blk + 1'b1;
                            memRdReq  <= 1'b1;
                            memRdAddr <= blk_addr(IN_BASE, sig, blk + 1'b1);
                            state     <= RD_REQ;
                        end
                    end
                    WAIT_OUT: begin
                        if (outFifoReady) begin
                            state <= WR_CAP;
                        end
                    end
                    WR_CAP: begin
                        if (mcDataOutValid) begin
                            data      <= mcDataOut;
                            memWrReq  <= 1'b1;
                            memWrAddr <= blk_addr(OUT_BASE, sig, blk);
                            state     <= WR_REQ;
                        end
                    end
                    WR_REQ: begin
                        if (memWrGnt) begin
                            memWrReq       <= 1'b0;
                            accelWrBlkDone <= 1'b1;
                            state          <= ACK;
                        end
                    end
                    ACK: begin
                        if (blk == LAST) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            blk   <= blk + 1'b1;
                            state <= WR_CAP;
                        end
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        blk   <= '0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_mc_dma.sv
// tb_fft_mc_dma: scoreboard bench with a host-memory and accelerator responder.
// Define FFT_DMA_TIMEOUT_EN to also exercise the watchdog abort.
`timescale 1ns/1ps
module tb_fft_mc_dma;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start;
    logic [17:0]  sigNum;
    logic         busy, done, err;
    logic         memRdReq;
    logic [31:0]  memRdAddr;
    logic         memRdGnt, memRdValid;
    logic [511:0] memRdData;
    logic         memWrReq;
    logic [31:0]  memWrAddr;
    logic [511:0] memWrData;
    logic         memWrGnt;
    logic         loadInFifo;
    logic [511:0] mcDataIn;
    logic         inFifoEmpty, outFifoReady;
    logic [511:0] mcDataOut;
    logic         mcDataOutValid;
    logic         accelWrBlkDone;

    always #5 clk = ~clk;

    fft_mc_dma #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sigNum(sigNum),
        .busy(busy), .done(done), .err(err),
        .memRdReq(memRdReq), .memRdAddr(memRdAddr),
        .memRdGnt(memRdGnt), .memRdValid(memRdValid),
        .memRdData(memRdData),
        .memWrReq(memWrReq), .memWrAddr(memWrAddr),
        .memWrData(memWrData), .memWrGnt(memWrGnt),
        .loadInFifo(loadInFifo), .mcDataIn(mcDataIn),
        .inFifoEmpty(inFifoEmpty), .outFifoReady(outFifoReady),
        .mcDataOut(mcDataOut), .mcDataOutValid(mcDataOutValid),
        .accelWrBlkDone(accelWrBlkDone)
    );

    typedef struct {
        logic [31:0]  a;
        logic [511:0] d;
    } wr_t;

    logic [31:0]  rd_q[$];
    logic [511:0] push_q[$];
    wr_t          wr_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int ack_cnt = 0, done_cnt = 0, err_cnt = 0, lif_cnt = 0;
    int run_id = 0, run_seen = 0;
    int push_seen = 0, ack_seen = 0, wr_seen = 0, stall_cnt = 0;
    bit fifo_empty = 1'b1, no_valid = 1'b0;
    bit stall_blk5 = 1'b0, hold_chk = 1'b0;

    function automatic logic [511:0] rd_pat(input logic [31:0] a);
        return {16{a ^ 32'h5A5A_5A5A}};
    endfunction

    function automatic logic [511:0] out_pat(input int i);
        return {16{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic chk(input string nm, input logic [511:0] got,
                       input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic fail(input string nm, input int v);
        n_vec++;
        n_bad++;
        $display("FAIL %s: unexpected or timed out, value %0d", nm, v);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rdreq"}, memRdReq, 0);
        chk({tag, "_rdaddr"}, memRdAddr, 0);
        chk({tag, "_wrreq"}, memWrReq, 0);
        chk({tag, "_wraddr"}, memWrAddr, 0);
        chk({tag, "_wrdata"}, memWrData, 0);
        chk({tag, "_load"}, loadInFifo, 0);
        chk({tag, "_datain"}, mcDataIn, 0);
        chk({tag, "_ack"}, accelWrBlkDone, 0);
    endtask

    task automatic expect_run(input logic [31:0] rb, input logic [31:0] wb);
        wr_t w;
        for (int i = 0; i < 128; i++) begin
            rd_q.push_back(rb + 32'(i * 64));
            push_q.push_back(rd_pat(rb + 32'(i * 64)));
            w.a = wb + 32'(i * 64);
            w.d = out_pat(i);
            wr_q.push_back(w);
        end
    endtask

    task automatic kick(input logic [17:0] s);
        run_id++;
        cyc(1);
        sigNum = s;
        start  = 1'b1;
        cyc(1);
        start  = 1'b0;
        sigNum = '0;
    endtask

    task automatic wait_lif(input int target, input int l0);
        for (int i = 0; i < 3000 && lif_cnt - l0 < target; i++) cyc(1);
        if (lif_cnt - l0 < target) fail("lif_wait", lif_cnt - l0);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) cyc(1);
        if (done_cnt == d0) fail("done_wait", done_cnt - d0);
    endtask

    // Host memory and accelerator FIFO responder, driven on the falling edge.
    initial begin
        memRdGnt = 0; memRdValid = 0; memRdData = '0; memWrGnt = 0;
        outFifoReady = 0; mcDataOut = '0; mcDataOutValid = 0;
        inFifoEmpty = 1;
        forever begin
            @(negedge clk);
            if (run_seen != run_id) begin
                run_seen = run_id;
                push_seen = 0; ack_seen = 0; wr_seen = 0; stall_cnt = 0;
            end
            if (loadInFifo) push_seen++;
            if (accelWrBlkDone) ack_seen++;
            memRdValid = memRdGnt && !no_valid;
            memRdData  = rd_pat(memRdAddr);
            memRdGnt   = memRdReq && !memRdGnt;
            if (memWrGnt) begin
                memWrGnt = 1'b0;
            end else if (memWrReq) begin
                if (stall_blk5 && wr_seen == 5 && stall_cnt < 20) begin
                    stall_cnt++;
                end else begin
                    memWrGnt = 1'b1;
                    wr_seen++;
                end
            end
            outFifoReady   = (push_seen >= 128);
            mcDataOutValid = outFifoReady;
            mcDataOut      = out_pat(ack_seen);
            inFifoEmpty    = fifo_empty;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transfer.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            #1;
            if (memRdReq && memRdGnt) begin
                if (rd_q.size() == 0) fail("rd_extra", int'(memRdAddr));
                else chk("rd_addr", memRdAddr, rd_q.pop_front());
            end
            if (loadInFifo) begin
                lif_cnt++;
                if (push_q.size() == 0) fail("push_extra", lif_cnt);
                else chk("push_data", mcDataIn, push_q.pop_front());
            end
            if (memWrReq) begin
                if (wr_q.size() == 0) begin
                    fail("wr_extra", int'(memWrAddr));
                end else if (memWrGnt) begin
                    w = wr_q.pop_front();
                    chk("wr_addr", memWrAddr, w.a);
                    chk("wr_data", memWrData, w.d);
                end else begin
                    chk("wr_addr_hold", memWrAddr, wr_q[0].a);
                    chk("wr_data_hold", memWrData, wr_q[0].d);
                end
            end
            if (accelWrBlkDone) ack_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (hold_chk) begin
                chk("rd_req_hold", memRdReq, 0);
                chk("busy_hold", busy, 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0, l0, e0, k;
        start = 0;
        sigNum = '0;
        cyc(3);
        chk_zero("reset");
        rst = 1'b0;
        cyc(2);

        expect_run(32'h0000_6000, 32'h1000_6000);
        fifo_empty = 1'b0;
        stall_blk5 = 1'b1;
        a0 = ack_cnt; d0 = done_cnt; l0 = lif_cnt;
        kick(3);
        hold_chk = 1'b1;
        cyc(50);
        hold_chk = 1'b0;
        fifo_empty = 1'b1;
        wait_lif(10, l0);
        sigNum = 18'd7;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        sigNum = '0;
        wait_done(d0);
        cyc(1);
        chk("run1_busy_end", busy, 0);
        chk("run1_loads", lif_cnt - l0, 128);
        chk("run1_acks", ack_cnt - a0, 128);
        chk("run1_dones", done_cnt - d0, 1);
        chk("run1_rdq", rd_q.size(), 0);
        chk("run1_wrq", wr_q.size(), 0);
        stall_blk5 = 1'b0;

        expect_run(32'h0000_2000, 32'h1000_2000);
        d0 = done_cnt; l0 = lif_cnt;
        kick(1);
        wait_lif(40, l0);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        cyc(2);
        rst = 1'b0;
        rd_q.delete();
        push_q.delete();
        wr_q.delete();
        cyc(20);
        chk("midrst_nodone", done_cnt - d0, 0);
        chk("midrst_idle", busy, 0);

        expect_run(32'h0000_4000, 32'h1000_4000);
        a0 = ack_cnt; d0 = done_cnt; l0 = lif_cnt;
        kick(2);
        wait_done(d0);
        cyc(1);
        chk("run3_loads", lif_cnt - l0, 128);
        chk("run3_acks", ack_cnt - a0, 128);
        chk("run3_dones", done_cnt - d0, 1);
        chk("run3_pushq", push_q.size(), 0);

`ifdef FFT_DMA_TIMEOUT_EN
        rd_q.push_back(32'h0000_6000);
        no_valid = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        kick(3);
        k = 0;
        while (!(memRdReq && memRdGnt) && k < 20) begin
            cyc(1);
            k++;
        end
        if (k >= 20) fail("tmo_grant_wait", k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (err) begin
                k = i;
                break;
            end
        end
        chk("tmo_latency", k, 16);
        chk("tmo_busy", busy, 0);
        cyc(1);
        chk("tmo_err_pulse", err, 0);
        cyc(5);
        chk("tmo_err_count", err_cnt - e0, 1);
        chk("tmo_nodone", done_cnt - d0, 0);
        chk("tmo_rdreq", memRdReq, 0);
        no_valid = 1'b0;
        rd_q.delete();
`else
        e0 = err_cnt;
        chk("err_tied", err_cnt - e0, 0);
`endif

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
